// File: rtl/tpu_ctrl_pkg.sv
// Shared constants, opcode encodings and fetch FSM states for the TPU control path.
package tpu_ctrl_pkg;

    localparam int unsigned INS_LEN = 54;
    localparam int unsigned ADDR_W  = 10;

    // Opcode occupies the top OPC_W bits of an instruction word.
    localparam int unsigned OPC_W = 4;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;
    localparam logic [OPC_W-1:0] OP_JUMP = 4'hE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_ctrl.sv
// Fetch sequencer: walks the instruction cache from start_addr, executes HALT/JUMP
// locally and issues all other words to the decoder through a one-entry output register.
module instruction_fetch_ctrl
    import tpu_ctrl_pkg::*;
#(
    parameter int unsigned INS_LEN = tpu_ctrl_pkg::INS_LEN,
    parameter int unsigned ADDR_W  = tpu_ctrl_pkg::ADDR_W,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_addr,
    input  logic               abort,
    output logic               icache_rd_en,
    output logic [ADDR_W-1:0]  icache_rd_addr,
    input  logic [INS_LEN-1:0] icache_rd_data,
    output logic               ins_valid,
    input  logic               ins_ready,
    output logic [INS_LEN-1:0] ins_data,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  pc,
    output logic [CNT_W-1:0]   issued_cnt
);

    fetch_state_e       state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               valid_q;
    logic [INS_LEN-1:0] data_q;
    logic               done_q;

    logic               fetch_ok;
    logic               handshake;
    logic [OPC_W-1:0]   opcode;

    assign fetch_ok  = (state_q == RUN) && (!valid_q || ins_ready);
    assign handshake = valid_q && ins_ready;
    assign opcode    = icache_rd_data[INS_LEN-1 -: OPC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (handshake) begin
                valid_q <= 1'b0;
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
            // Abort overrides everything but still lets the handshake above count.
            if (abort) begin
                valid_q <= 1'b0;
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start) begin
                            pc_q    <= start_addr;
                            cnt_q   <= '0;
                            state_q <= RUN;
                        end
                    end
                    RUN: begin
                        if (fetch_ok) begin
                            if (opcode == OP_HALT) begin
                                state_q <= DRAIN;
                            end else if (opcode == OP_JUMP) begin
                                pc_q <= icache_rd_data[ADDR_W-1:0];
                            end else begin
                                data_q  <= icache_rd_data;
                                valid_q <= 1'b1;
                                pc_q    <= pc_q + ADDR_W'(1);
                            end
                        end
                    end
                    DRAIN: begin
                        if (!valid_q || ins_ready) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign icache_rd_en   = fetch_ok;
    assign icache_rd_addr = pc_q;
    assign ins_valid      = valid_q;
    assign ins_data       = data_q;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign pc             = pc_q;
    assign issued_cnt     = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Self-checking bench: cache contents live in a bench array; expected issue streams come
// from walking the program in that array, independent of the controller's cycle behaviour.
module tb_instruction_fetch_ctrl;

    localparam int unsigned INS_LEN = 54;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned CNT_W   = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [ADDR_W-1:0]  start_addr = '0;
    logic               abort = 1'b0;
    logic               icache_rd_en;
    logic [ADDR_W-1:0]  icache_rd_addr;
    logic [INS_LEN-1:0] icache_rd_data;
    logic               ins_valid;
    logic               ins_ready = 1'b1;
    logic [INS_LEN-1:0] ins_data;
    logic               busy;
    logic               done;
    logic [ADDR_W-1:0]  pc;
    logic [CNT_W-1:0]   issued_cnt;

    logic [INS_LEN-1:0] mem [0:1023];

    int n_cmp = 0;
    int n_err = 0;

    logic [INS_LEN-1:0] exp_q[$];
    logic [ADDR_W-1:0]  exp_pc;
    logic [INS_LEN-1:0] got_q[$];
    int                 got_cyc[$];
    logic               done_seen;

    instruction_fetch_ctrl #(
        .INS_LEN(INS_LEN),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .start_addr    (start_addr),
        .abort         (abort),
        .icache_rd_en  (icache_rd_en),
        .icache_rd_addr(icache_rd_addr),
        .icache_rd_data(icache_rd_data),
        .ins_valid     (ins_valid),
        .ins_ready     (ins_ready),
        .ins_data      (ins_data),
        .busy          (busy),
        .done          (done),
        .pc            (pc),
        .issued_cnt    (issued_cnt)
    );

    always #5 clk = ~clk;

    always_comb icache_rd_data = mem[icache_rd_addr];

    function automatic logic [INS_LEN-1:0] w_rand();
        logic [INS_LEN-1:0] w;
        w[31:0]  = $urandom;
        w[53:32] = 22'($urandom);
        return w;
    endfunction

    function automatic logic [INS_LEN-1:0] w_norm();
        logic [INS_LEN-1:0] w;
        w = w_rand();
        w[53:50] = 4'($urandom_range(13));
        return w;
    endfunction

    function automatic logic [INS_LEN-1:0] w_jump(input logic [ADDR_W-1:0] t);
        logic [INS_LEN-1:0] w;
        w = w_rand();
        w[53:50] = 4'hE;
        w[9:0]   = t;
        return w;
    endfunction

    function automatic logic [INS_LEN-1:0] w_halt();
        logic [INS_LEN-1:0] w;
        w = w_rand();
        w[53:50] = 4'hF;
        return w;
    endfunction

    // Reference: execute the program architecturally, collecting issued words.
    task automatic model_walk(input logic [ADDR_W-1:0] sa);
        logic [ADDR_W-1:0]  p;
        logic [INS_LEN-1:0] w;
        exp_q.delete();
        p = sa;
        exp_pc = sa;
        for (int s = 0; s < 4096; s++) begin
            w = mem[p];
            if (w[53:50] == 4'hF) begin
                exp_pc = p;
                break;
            end else if (w[53:50] == 4'hE) begin
                p = w[9:0];
            end else begin
                exp_q.push_back(w);
                p = p + 10'd1;
            end
        end
    endtask

    // Run one program to completion with random ready; inject_at >= 0 fires a stray start.
    task automatic run_prog(input string name, input logic [ADDR_W-1:0] sa,
                            input int unsigned ready_pct, input int inject_at);
        logic               pv, pr;
        logic [INS_LEN-1:0] pd;
        model_walk(sa);
        got_q.delete();
        got_cyc.delete();
        done_seen = 1'b0;
        pv = 1'b0; pr = 1'b0; pd = '0;
        @(negedge clk);
        start_addr = sa;
        start = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            start = (c == inject_at);
            start_addr = (c == inject_at) ? ~sa : sa;
            ins_ready = ($urandom_range(99) < ready_pct);
            #1;
            if (pv && !pr) begin
                n_cmp++;
                if (ins_valid !== 1'b1 || ins_data !== pd) begin
                    n_err++;
                    $display("FAIL %s hold: valid=%b data=%h required valid=1 data=%h", name, ins_valid, ins_data, pd);
                end
            end
            pv = ins_valid; pr = ins_ready; pd = ins_data;
            if (ins_valid && ins_ready) begin
                got_q.push_back(ins_data);
                got_cyc.push_back(c);
            end
            if (done) begin
                done_seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        n_cmp++;
        if (done_seen !== 1'b1) begin
            n_err++;
            $display("FAIL %s done: not seen within budget, required a done pulse", name);
        end
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL %s count: got %0d issued, required %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL %s word[%0d]: got %h required %h", name, i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (pc !== exp_pc || issued_cnt !== CNT_W'(exp_q.size()) || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s end: pc=%0d cnt=%0d busy=%b required pc=%0d cnt=%0d busy=0",
                     name, pc, issued_cnt, busy, exp_pc, exp_q.size());
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0 || ins_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s after: done=%b valid=%b required 0 0", name, done, ins_valid);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({ins_valid, busy, done, icache_rd_en} !== 4'b0 || pc !== '0 || issued_cnt !== '0 || ins_data !== '0) begin
            n_err++;
            $display("FAIL reset: valid=%b busy=%b done=%b rd_en=%b pc=%0d cnt=%0d required all 0",
                     ins_valid, busy, done, icache_rd_en, pc, issued_cnt);
        end
    endtask

    task automatic test_basic_timing();
        logic [INS_LEN-1:0] a, b;
        a = w_norm(); b = w_norm();
        mem[5] = a; mem[6] = b; mem[7] = w_halt();
        ins_ready = 1'b1;
        @(negedge clk);
        start_addr = 10'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b1 || ins_valid !== 1'b0 || icache_rd_en !== 1'b1 || icache_rd_addr !== 10'd5) begin
            n_err++;
            $display("FAIL t1 cyc1: busy=%b valid=%b rd_en=%b addr=%0d required 1 0 1 5", busy, ins_valid, icache_rd_en, icache_rd_addr);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (ins_valid !== 1'b1 || ins_data !== a || pc !== 10'd6) begin
            n_err++;
            $display("FAIL t1 A: valid=%b data=%h pc=%0d required 1 %h 6", ins_valid, ins_data, pc, a);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (ins_valid !== 1'b1 || ins_data !== b || pc !== 10'd7) begin
            n_err++;
            $display("FAIL t1 B: valid=%b data=%h pc=%0d required 1 %h 7", ins_valid, ins_data, pc, b);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (ins_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL t1 halt: valid=%b done=%b busy=%b required 0 0 1", ins_valid, done, busy);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || pc !== 10'd7 || issued_cnt !== 16'd2) begin
            n_err++;
            $display("FAIL t1 done: done=%b busy=%b pc=%0d cnt=%0d required 1 0 7 2", done, busy, pc, issued_cnt);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL t1 pulse: done=%b required 0", done);
        end
    endtask

    task automatic test_stall();
        logic [INS_LEN-1:0] a, b;
        logic [INS_LEN-1:0] acc[$];
        logic seen;
        a = w_norm(); b = w_norm();
        mem[5] = a; mem[6] = b; mem[7] = w_halt();
        ins_ready = 1'b1;
        seen = 1'b0;
        @(negedge clk);
        start_addr = 10'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        ins_ready = 1'b0;
        repeat (3) begin
            #1;
            n_cmp++;
            if (ins_valid !== 1'b1 || ins_data !== a || icache_rd_en !== 1'b0 || pc !== 10'd6) begin
                n_err++;
                $display("FAIL t2 stall: valid=%b data=%h rd_en=%b pc=%0d required 1 %h 0 6", ins_valid, ins_data, icache_rd_en, pc, a);
            end
            @(negedge clk);
        end
        ins_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (ins_valid) acc.push_back(ins_data);
            if (done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (seen !== 1'b1 || acc.size() != 2 || issued_cnt !== 16'd2) begin
            n_err++;
            $display("FAIL t2 end: done_seen=%b accepted=%0d cnt=%0d required 1 2 2", seen, acc.size(), issued_cnt);
        end else begin
            n_cmp++;
            if (acc[0] !== a || acc[1] !== b) begin
                n_err++;
                $display("FAIL t2 order: got %h,%h required %h,%h", acc[0], acc[1], a, b);
            end
        end
    endtask

    task automatic test_jump();
        mem[10] = w_norm(); mem[11] = w_jump(10'd20);
        mem[20] = w_norm(); mem[21] = w_halt();
        run_prog("t3 jump", 10'd10, 100, -1);
        n_cmp++;
        if (got_cyc.size() != 2 || got_cyc[1] - got_cyc[0] != 2) begin
            n_err++;
            $display("FAIL t3 bubble: accepts=%0d gap=%0d required 2 accepts gap 2",
                     got_cyc.size(), (got_cyc.size() == 2) ? got_cyc[1] - got_cyc[0] : -1);
        end
    endtask

    task automatic test_wrap();
        mem[1023] = w_norm(); mem[0] = w_halt();
        run_prog("t4 wrap", 10'd1023, 100, -1);
    endtask

    task automatic test_abort_loop();
        int vcnt, dcnt;
        vcnt = 0; dcnt = 0;
        mem[0] = w_jump(10'd0);
        ins_ready = 1'b1;
        @(negedge clk);
        start_addr = 10'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) begin
            #1;
            if (ins_valid) vcnt++;
            if (done) dcnt++;
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || ins_valid !== 1'b0 || pc !== 10'd0) begin
            n_err++;
            $display("FAIL t5 abort: busy=%b done=%b valid=%b pc=%0d required 0 0 0 0", busy, done, ins_valid, pc);
        end
        repeat (3) begin
            @(negedge clk); #1;
            if (done) dcnt++;
        end
        n_cmp++;
        if (vcnt != 0 || dcnt != 0) begin
            n_err++;
            $display("FAIL t5 loop: valid cycles=%0d done pulses=%0d required 0 0", vcnt, dcnt);
        end
    endtask

    task automatic test_start_abort();
        @(negedge clk);
        start_addr = 10'd33; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL t6 start+abort: busy=%b required 0", busy);
        end
        for (int i = 0; i < 6; i++) mem[100 + i] = w_norm();
        mem[106] = w_halt();
        run_prog("t6 stray start", 10'd100, 100, 2);
    endtask

    task automatic test_reset_midrun();
        for (int i = 0; i < 8; i++) mem[200 + i] = w_norm();
        mem[208] = w_halt();
        ins_ready = 1'b1;
        @(negedge clk);
        start_addr = 10'd200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ins_valid, busy, done, icache_rd_en} !== 4'b0 || pc !== '0 || issued_cnt !== '0 || ins_data !== '0) begin
            n_err++;
            $display("FAIL reset midrun: valid=%b busy=%b done=%b rd_en=%b pc=%0d cnt=%0d required all 0",
                     ins_valid, busy, done, icache_rd_en, pc, issued_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] s, t;
        int unsigned l1, l2, gap;
        for (int n = 0; n < 15; n++) begin
            s   = 10'($urandom);
            l1  = $urandom_range(12, 1);
            l2  = $urandom_range(12, 1);
            gap = $urandom_range(50, 1);
            for (int unsigned i = 0; i < l1; i++) mem[s + 10'(i)] = w_norm();
            t = s + 10'(l1) + 10'd1 + 10'(gap);
            mem[s + 10'(l1)] = w_jump(t);
            for (int unsigned i = 0; i < l2; i++) mem[t + 10'(i)] = w_norm();
            mem[t + 10'(l2)] = w_halt();
            run_prog("rand", s, $urandom_range(100, 30), -1);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        test_reset();
        test_basic_timing();
        test_stall();
        test_jump();
        test_wrap();
        test_abort_loop();
        test_start_abort();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
